// File: rtl/tl45_dprf.sv
// TL45 general-purpose register file: two combinational read ports, one commit port,
// a registered forwarding bus and a clear sequencer that zeroes the file entry by entry.
module tl45_dprf #(
   parameter int XLEN = 32,
   parameter int AW   = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [AW-1:0]   i_read_a1,
   input  logic [AW-1:0]   i_read_a2,
   output logic [XLEN-1:0] o_d1,
   output logic [XLEN-1:0] o_d2,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_reg,
   input  logic [XLEN-1:0] i_wr_data,
   output logic [AW-1:0]   o_of_reg,
   output logic [XLEN-1:0] o_of_data,
   input  logic            i_clear,
   output logic            o_busy
);

   localparam int NREG = 2**AW;
   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   cnt_q;
   logic            busy_q;
   logic [AW-1:0]   of_reg_q;
   logic [XLEN-1:0] of_data_q;
   logic [XLEN-1:0] rf_q [NREG];

   // Commit contract: i_wr_en is a one-cycle strobe with no back-pressure; the
   // parent must hold the pipe while o_busy is high, since commits are then dropped.
   // A commit also loses to a same-cycle i_clear and never touches entry 0.
   logic commit;
   assign commit = i_wr_en && (i_wr_reg != '0) && (state_q == ST_IDLE) && !i_clear;

   assign o_d1 = ((i_read_a1 == '0) || (state_q == ST_CLEAR)) ? '0 :
                 (commit && (i_wr_reg == i_read_a1))          ? i_wr_data :
                                                                rf_q[i_read_a1];

   assign o_d2 = ((i_read_a2 == '0) || (state_q == ST_CLEAR)) ? '0 :
                 (commit && (i_wr_reg == i_read_a2))          ? i_wr_data :
                                                                rf_q[i_read_a2];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (commit && (i_wr_reg == AW'(i))) begin
               rf_q[i] <= i_wr_data;
            end else if ((state_q == ST_CLEAR) && (cnt_q == AW'(i))) begin
               rf_q[i] <= '0;
            end
         end
      end
   end

   // Sequencer and forwarding bus share one register stage so o_busy and the
   // forward both change on the same edge that starts or ends a clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         of_reg_q  <= '0;
         of_data_q <= '0;
      end else begin
         of_reg_q  <= commit ? i_wr_reg  : '0;
         of_data_q <= commit ? i_wr_data : '0;
         case (state_q)
            ST_IDLE: begin
               if (i_clear) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= AW'(1);
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (cnt_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_of_reg  = of_reg_q;
   assign o_of_data = of_data_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_tl45_dprf.sv
// Directed and randomized checks of tl45_dprf against a whole-file reference model
// that applies a clear to every entry at once.
module tb_tl45_dprf;

   localparam int XLEN = 32;
   localparam int AW   = 4;
   localparam int NREG = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   a1, a2, wr_reg, of_reg;
   logic [XLEN-1:0] d1, d2, wr_data, of_data;
   logic            wr_en, clear, busy;

   int n_checks = 0;
   int n_errors = 0;
   int busy_seen = 0;

   logic [XLEN-1:0] m_rf [NREG];
   int              m_left;
   logic [AW-1:0]   m_of_reg;
   logic [XLEN-1:0] m_of_data;

   tl45_dprf #(.XLEN(XLEN), .AW(AW)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_read_a1 (a1),
      .i_read_a2 (a2),
      .o_d1      (d1),
      .o_d2      (d2),
      .i_wr_en   (wr_en),
      .i_wr_reg  (wr_reg),
      .i_wr_data (wr_data),
      .o_of_reg  (of_reg),
      .o_of_data (of_data),
      .i_clear   (clear),
      .o_busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_commit();
      return wr_en && (wr_reg != 0) && (m_left == 0) && !clear;
   endfunction

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0 || m_left != 0) return '0;
      if (m_commit() && wr_reg == a) return wr_data;
      return m_rf[a];
   endfunction

   task automatic model_reset();
      foreach (m_rf[i]) m_rf[i] = '0;
      m_left    = 0;
      m_of_reg  = '0;
      m_of_data = '0;
   endtask

   task automatic model_edge();
      logic c;
      c = m_commit();
      m_of_reg  = c ? wr_reg : '0;
      m_of_data = c ? wr_data : '0;
      if (m_left != 0) begin
         m_left--;
      end else if (clear) begin
         m_left = NREG - 1;
         foreach (m_rf[i]) m_rf[i] = '0;
      end else if (c) begin
         m_rf[wr_reg] = wr_data;
      end
   endtask

   task automatic drv(input logic we, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic clr);
      wr_en   = we;
      wr_reg  = wr;
      wr_data = wd;
      a1      = r1;
      a2      = r2;
      clear   = clr;
   endtask

   task automatic drv_rand(input logic clr);
      drv(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), 32'($urandom),
          AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)), clr);
   endtask

   // Inputs are already driven; check reads, take one edge, check registered outputs.
   task automatic tick();
      #1;
      chk("rd_d1", d1, m_read(a1));
      chk("rd_d2", d2, m_read(a2));
      @(posedge clk);
      model_edge();
      #1;
      chk("of_reg", 32'(of_reg), 32'(m_of_reg));
      chk("of_data", of_data, m_of_data);
      chk("busy", 32'(busy), 32'(m_left != 0));
      if (busy) busy_seen++;
   endtask

   initial begin
      model_reset();
      drv(1'b0, '0, '0, 4'd3, 4'd0, 1'b0);
      rst = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_of_reg", 32'(of_reg), 32'd0);
      chk("rst_of_data", of_data, 32'd0);
      chk("rst_d1", d1, 32'd0);
      chk("rst_d2", d2, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Plain commit, read back, one-cycle forward.
      tick();
      drv(1'b1, 4'd3, 32'hDEADBEEF, 4'd1, 4'd0, 1'b0);
      tick();
      chk("t1_of_reg", 32'(of_reg), 32'd3);
      chk("t1_of_data", of_data, 32'hDEADBEEF);
      drv(1'b0, '0, '0, 4'd3, 4'd3, 1'b0);
      tick();
      chk("t1_rd", d1, 32'hDEADBEEF);
      chk("t1_of_gone", 32'(of_reg), 32'd0);

      // Same-cycle bypass on both ports, then a write to r0.
      drv(1'b1, 4'd5, 32'h12345678, 4'd5, 4'd5, 1'b0);
      #1;
      chk("t2_byp1", d1, 32'h12345678);
      chk("t2_byp2", d2, 32'h12345678);
      tick();
      drv(1'b1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd5, 1'b0);
      #1;
      chk("t2_r0_rd", d1, 32'd0);
      tick();
      chk("t2_r0_of", 32'(of_reg), 32'd0);

      // Back-to-back commits to one register.
      drv(1'b1, 4'd7, 32'd1, 4'd7, 4'd0, 1'b0);
      tick();
      chk("t3_of1", of_data, 32'd1);
      drv(1'b1, 4'd7, 32'd2, 4'd7, 4'd0, 1'b0);
      tick();
      chk("t3_of2_reg", 32'(of_reg), 32'd7);
      chk("t3_of2", of_data, 32'd2);
      drv(1'b0, '0, '0, 4'd7, 4'd7, 1'b0);
      tick();
      chk("t3_rd", d1, 32'd2);

      // Fill, then clear with a colliding commit; commits during clear are dropped.
      for (int i = 1; i < NREG; i++) begin
         drv(1'b1, AW'(i), 32'(i), AW'(i), 4'd0, 1'b0);
         tick();
      end
      busy_seen = 0;
      drv(1'b1, 4'd4, 32'hAA, 4'd4, 4'd9, 1'b1);
      tick();
      for (int i = 0; i < NREG - 1; i++) begin
         drv(1'b1, AW'($urandom_range(1, NREG - 1)), 32'($urandom),
             AW'($urandom_range(1, NREG - 1)), 4'd4, 1'b0);
         tick();
      end
      chk("t4_len", 32'(busy_seen), 32'd15);
      for (int i = 1; i < NREG; i++) begin
         drv(1'b0, '0, '0, AW'(i), 4'd4, 1'b0);
         tick();
      end
      chk("t4_r4", d2, 32'd0);

      // Asynchronous reset at cnt = 6.
      drv(1'b0, '0, '0, '0, '0, 1'b1);
      tick();
      drv(1'b0, '0, '0, 4'd2, 4'd5, 1'b0);
      repeat (5) tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_of_reg", 32'(of_reg), 32'd0);
      chk("t5_of_data", of_data, 32'd0);
      chk("t5_d1", d1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drv(1'b1, 4'd2, 32'h55, 4'd1, 4'd0, 1'b0);
      tick();
      chk("t5_of", of_data, 32'h55);
      drv(1'b0, '0, '0, 4'd2, 4'd0, 1'b0);
      tick();
      chk("t5_rd", d1, 32'h55);

      // Clear re-pulsed at cnt = 10 must not extend the sequence.
      busy_seen = 0;
      drv(1'b0, '0, '0, '0, '0, 1'b1);
      tick();
      drv(1'b0, '0, '0, 4'd2, 4'd3, 1'b0);
      repeat (9) tick();
      drv(1'b1, 4'd6, 32'h66, 4'd6, 4'd2, 1'b1);
      tick();
      drv(1'b0, '0, '0, 4'd6, 4'd2, 1'b0);
      repeat (5) tick();
      chk("t6_len", 32'(busy_seen), 32'd15);
      chk("t6_idle", 32'(busy), 32'd0);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         drv_rand(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tl45_dprf.md
Name: tl45_dprf

Overview:
- Dual-read, single-write general-purpose register file for the TL45 core.
- Answers the register-read stage's two DPRF address ports combinationally and accepts commits from the writeback stage.
- Drives a registered operand-forwarding bus showing the most recent commit.
- Provides a multi-cycle clear sequencer, used on debug reset or context wipe, that stalls the pipe while it runs.

Parameters:
- XLEN, 32, data width of each register
- AW, 4, register address width; register count is 2**AW, and register 0 is hardwired to zero

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous, active-high reset
- i_read_a1  in  AW  read address, port 1
- i_read_a2  in  AW  read address, port 2
- o_d1  out  XLEN  read data, port 1 (combinational)
- o_d2  out  XLEN  read data, port 2 (combinational)
- i_wr_en  in  1  commit strobe from writeback
- i_wr_reg  in  AW  destination register of the commit
- i_wr_data  in  XLEN  commit data
- o_of_reg  out  AW  forwarding bus register number; 0 means no forward
- o_of_data  out  XLEN  forwarding bus data
- i_clear  in  1  single-cycle request to zero all registers
- o_busy  out  1  clear sequence in progress; the parent ORs it into the pipe stall

Behaviour:
- Reset (async, active-high):
  - all registers, o_of_reg, o_of_data and o_busy go to 0 immediately; the sequencer goes to IDLE and the counter to 0.
  - Reset asserted mid-clear aborts the sequence; the file is still fully zero.
- Storage: 2**AW entries of XLEN bits.
  - Entry 0 is never written and always reads 0.
- Commit rule: a commit happens on a rising edge when all of the following hold:
  - i_wr_en = 1
  - i_wr_reg != 0
  - state = IDLE
  - i_clear = 0
- Read ports (purely combinational, zero latency), for each port n:
  - a_n == 0 -> 0.
  - State CLEAR -> 0. Every entry is zero or about to be zeroed.
  - Commit condition true this cycle and i_wr_reg == a_n -> i_wr_data (write-through bypass).
  - Otherwise -> stored entry.
  - Both ports may read the same address; both return the same value.
- Forwarding bus, registered with 1-cycle latency:
  - After an edge with a commit: o_of_reg = committed register, o_of_data = committed data.
  - After any other edge: o_of_reg = 0, o_of_data = 0. The bus is valid for exactly one cycle per commit.
  - Consumers use register 0 as "no match".
- Clear sequencer, states IDLE and CLEAR, 4-bit counter cnt:
  - IDLE, i_clear = 1: go to CLEAR with cnt = 1, o_busy = 1 from the next cycle. A simultaneous i_wr_en is dropped, because clear wins.
  - CLEAR, each edge: entry[cnt] <= 0.
    - If cnt == 2**AW-1, go to IDLE with o_busy = 0 and cnt = 0.
    - Otherwise cnt <= cnt+1.
  - The sequence lasts 2**AW-1 cycles (15 by default).
  - In CLEAR, i_wr_en and i_clear are ignored: no commit, no restart, and o_of_reg stays 0.
  - o_busy is registered: it is high in exactly the cycles spent in CLEAR.
- Write to register 0 with i_wr_en = 1: no storage change, no bypass, and o_of_reg = 0 on the next cycle.
- Back-to-back commits to the same register: the last one wins, and each produces its own one-cycle forward.

Test Plan:
1. Reset, then read a1=3 and a2=0 -> o_d1=0, o_d2=0. Commit r3=0xDEADBEEF. The next cycle reads r3 -> 0xDEADBEEF, and o_of_reg=3, o_of_data=0xDEADBEEF for exactly one cycle, then 0/0.
2. Bypass: a1=5, a2=5 while committing r5=0x12345678 in the same cycle -> o_d1=o_d2=0x12345678 in that cycle. Repeat with a commit to r0=0xFFFFFFFF and a1=0 -> o_d1=0, and o_of_reg=0 the next cycle.
3. Back-to-back: commit r7=1, then r7=2 on consecutive cycles -> o_of_reg=7 with data 1 then 2; r7 reads 2 afterwards.
4. Clear: fill r1..r15 with their own index, then pulse i_clear together with a commit r4=0xAA -> o_busy high for 15 cycles. During CLEAR, reads return 0 and commits are ignored. Afterwards all reads return 0, including r4 (the write was dropped).
5. Reset mid-clear: assert i_reset asynchronously (between clock edges) at cnt=6 -> o_busy=0 and all outputs 0 immediately. The next commit r2=0x55 works normally.
6. i_clear re-pulsed at cnt=10 -> ignored; the sequence still ends after 15 total cycles.
